// File: rtl/image_stats_ctrl_pkg.sv
// image_stats_ctrl_pkg: shared FSM encoding and ROI field layout for the image statistics controller
//   st_e      : 3-bit controller state
//   ROI_*_LSB : bit offsets of the 8-bit fields in the packed {bottom,top,right,left} ROI word
package image_stats_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_EVAL  = 3'd4
    } st_e;

    localparam int ROI_FIELD_W    = 8;
    localparam int ROI_LEFT_LSB   = 0;
    localparam int ROI_RIGHT_LSB  = 8;
    localparam int ROI_TOP_LSB    = 16;
    localparam int ROI_BOTTOM_LSB = 24;

endpackage

// File: rtl/image_stats_ctrl_ae_step.sv
// ae_step: combinational auto-exposure step with dead band and clamping
//   ae_en_i                : enable; when low the exposure holds
//   sum_i                  : captured frame sum
//   target_i, hyst_i       : dead band centre and half-width
//   exp_i                  : current exposure
//   step_i                 : exposure increment/decrement
//   exp_min_i, exp_max_i   : clamp limits (inverted limits freeze the exposure)
//   exp_o                  : next exposure
module ae_step (
    input  logic        ae_en_i,
    input  logic [31:0] sum_i,
    input  logic [31:0] target_i,
    input  logic [31:0] hyst_i,
    input  logic [15:0] exp_i,
    input  logic [15:0] step_i,
    input  logic [15:0] exp_min_i,
    input  logic [15:0] exp_max_i,
    output logic [15:0] exp_o
);

    logic [32:0] lo_w, hi_w;
    logic [31:0] lo, hi;
    logic [16:0] up_w;
    logic [15:0] up, dn_w, dn;

    // Band edges are formed in 33 bits so both ends saturate instead of wrapping
    assign lo_w = {1'b0, target_i} - {1'b0, hyst_i};
    assign hi_w = {1'b0, target_i} + {1'b0, hyst_i};
    assign lo   = lo_w[32] ? '0 : lo_w[31:0];
    assign hi   = hi_w[32] ? '1 : hi_w[31:0];

    assign up_w = {1'b0, exp_i} + {1'b0, step_i};
    assign up   = (up_w > {1'b0, exp_max_i}) ? exp_max_i : up_w[15:0];
    assign dn_w = exp_i - step_i;
    // Underflow of the subtraction lands on the lower clamp
    assign dn   = (exp_i < step_i || dn_w < exp_min_i) ? exp_min_i : dn_w;

    always_comb begin
        exp_o = (!ae_en_i || exp_min_i > exp_max_i) ? exp_i :
                (sum_i < lo) ? up :
                (sum_i > hi) ? dn : exp_i;
    end

endmodule

// File: rtl/image_stats_ctrl.sv
// image_stats_ctrl: per-frame sequencer for a statistics accumulator with auto-exposure update
//   c, rst_n        : clock, asynchronous active-low reset
//   fsync, dv       : frame-start pulse and row data-valid
//   roi_cfg         : requested ROI, shadowed to stats_roi at frame start
//   stats_sum       : accumulator output, captured after the drain delay
//   ae_en, target, hyst, step, exp_min, exp_max : auto-exposure controls
//   clr_err         : clears the sticky overrun flag
//   stats_rst       : accumulator clear (IDLE and CLEAR)
//   frame_sum, frame_sum_valid, exposure, frame_cnt, overrun, busy : results/status
module image_stats_ctrl
    import image_stats_ctrl_pkg::*;
#(
    parameter int          LINES    = 480,
    parameter int          DRAIN    = 4,
    parameter logic [15:0] EXP_INIT = 16'h0400
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        fsync,
    input  logic        dv,
    input  logic [31:0] roi_cfg,
    input  logic [31:0] stats_sum,
    input  logic        ae_en,
    input  logic [31:0] target,
    input  logic [31:0] hyst,
    input  logic [15:0] step,
    input  logic [15:0] exp_min,
    input  logic [15:0] exp_max,
    input  logic        clr_err,
    output logic        stats_rst,
    output logic [31:0] stats_roi,
    output logic [31:0] frame_sum,
    output logic        frame_sum_valid,
    output logic [15:0] exposure,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic        busy
);

    localparam logic [10:0] LINES_C = 11'(LINES);
    localparam logic [3:0]  DRAIN_C = 4'(DRAIN);

    st_e         state_q, state_d;
    logic        pend_q, pend_d;
    logic        dv_d1_q;
    logic [10:0] row_q, row_d, row_inc;
    logic [3:0]  drn_q, drn_d;
    logic [31:0] roi_q, roi_d;
    logic [31:0] sum_q, sum_d;
    logic        valid_q, valid_d;
    logic [15:0] exp_q, exp_d, exp_ae;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        ovr_q, ovr_d, ovr_set;
    logic        fall;

    ae_step u_ae_step (
        .ae_en_i   (ae_en),
        .sum_i     (stats_sum),
        .target_i  (target),
        .hyst_i    (hyst),
        .exp_i     (exp_q),
        .step_i    (step),
        .exp_min_i (exp_min),
        .exp_max_i (exp_max),
        .exp_o     (exp_ae)
    );

    assign fall    = dv_d1_q & ~dv;
    assign row_inc = row_q + 11'd1;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            dv_d1_q     <= 1'b0;
            row_q       <= '0;
            drn_q       <= '0;
            roi_q       <= '0;
            sum_q       <= '0;
            valid_q     <= 1'b0;
            exp_q       <= EXP_INIT;
            frame_cnt_q <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            dv_d1_q     <= dv;
            row_q       <= row_d;
            drn_q       <= drn_d;
            roi_q       <= roi_d;
            sum_q       <= sum_d;
            valid_q     <= valid_d;
            exp_q       <= exp_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        row_d       = row_q;
        drn_d       = drn_q;
        roi_d       = roi_q;
        sum_d       = sum_q;
        valid_d     = 1'b0;
        exp_d       = exp_q;
        frame_cnt_d = frame_cnt_q;
        ovr_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fsync || pend_q) begin
                    roi_d   = roi_cfg;
                    pend_d  = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                row_d   = '0;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                // A new frame arriving mid-frame aborts the current one
                if (fsync) begin
                    ovr_set = 1'b1;
                    roi_d   = roi_cfg;
                    state_d = ST_CLEAR;
                end else if (fall) begin
                    row_d = row_inc;
                    if (row_inc == LINES_C) begin
                        drn_d   = DRAIN_C;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                pend_d = pend_q | fsync;
                drn_d  = drn_q - 4'd1;
                if (drn_q == 4'd1) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                pend_d      = pend_q | fsync;
                sum_d       = stats_sum;
                valid_d     = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                exp_d       = exp_ae;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ovr_d = ovr_set | (ovr_q & ~clr_err);
    end

    always_comb begin
        stats_rst = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
        busy      = state_q != ST_IDLE;
    end

    assign stats_roi       = roi_q;
    assign frame_sum       = sum_q;
    assign frame_sum_valid = valid_q;
    assign exposure        = exp_q;
    assign frame_cnt       = frame_cnt_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_image_stats_ctrl.sv
// tb_image_stats_ctrl: directed self-checking bench for image_stats_ctrl (LINES=4, DRAIN=4)
module tb_image_stats_ctrl;

    logic        c, rst_n, fsync, dv, ae_en, clr_err;
    logic [31:0] roi_cfg, stats_sum, target, hyst;
    logic [15:0] step, exp_min, exp_max;
    logic        stats_rst, frame_sum_valid, overrun, busy;
    logic [31:0] stats_roi, frame_sum;
    logic [15:0] exposure, frame_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'd0;

    image_stats_ctrl #(.LINES(4), .DRAIN(4), .EXP_INIT(16'h0400)) dut (
        .c               (c),
        .rst_n           (rst_n),
        .fsync           (fsync),
        .dv              (dv),
        .roi_cfg         (roi_cfg),
        .stats_sum       (stats_sum),
        .ae_en           (ae_en),
        .target          (target),
        .hyst            (hyst),
        .step            (step),
        .exp_min         (exp_min),
        .exp_max         (exp_max),
        .clr_err         (clr_err),
        .stats_rst       (stats_rst),
        .stats_roi       (stats_roi),
        .frame_sum       (frame_sum),
        .frame_sum_valid (frame_sum_valid),
        .exposure        (exposure),
        .frame_cnt       (frame_cnt),
        .overrun         (overrun),
        .busy            (busy)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick;
        @(posedge c);
        #1;
    endtask

    task automatic check_idle_reset(input string nm, input logic [15:0] exp_e);
        n_chk++; if (stats_rst !== 1'b1) begin n_fail++; $display("FAIL %s stats_rst got %0b exp 1", nm, stats_rst); end
        n_chk++; if (stats_roi !== 32'd0) begin n_fail++; $display("FAIL %s stats_roi got %0h exp 0", nm, stats_roi); end
        n_chk++; if (frame_sum !== 32'd0) begin n_fail++; $display("FAIL %s frame_sum got %0h exp 0", nm, frame_sum); end
        n_chk++; if (frame_sum_valid !== 1'b0) begin n_fail++; $display("FAIL %s valid got %0b exp 0", nm, frame_sum_valid); end
        n_chk++; if (exposure !== exp_e) begin n_fail++; $display("FAIL %s exposure got %0h exp %0h", nm, exposure, exp_e); end
        n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL %s frame_cnt got %0h exp 0", nm, frame_cnt); end
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL %s overrun got %0b exp 0", nm, overrun); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy got %0b exp 0", nm, busy); end
    endtask

    task automatic rows(input int n);
        for (int r = 0; r < n; r++) begin
            dv = 1'b1; tick; tick;
            dv = 1'b0; tick; tick;
        end
    endtask

    // Entered one cycle after IDLE->CLEAR; runs 4 rows, drain and capture
    task automatic frame_body(input logic [31:0] sum, input logic [15:0] exp_e, input int fs_at, input string nm);
        stats_sum = sum;
        for (int r = 0; r < 4; r++) begin
            dv = 1'b1; tick;
            if (r == 0) begin
                n_chk++; if (stats_rst !== 1'b0) begin n_fail++; $display("FAIL %s accum stats_rst got %0b exp 0", nm, stats_rst); end
            end
            tick;
            dv = 1'b0;
            if (r < 3) begin tick; tick; end
        end
        tick;
        for (int k = 1; k <= 4; k++) begin
            if (k == fs_at) fsync = 1'b1;
            tick;
            fsync = 1'b0;
            n_chk++; if (frame_sum_valid !== 1'b0) begin n_fail++; $display("FAIL %s early valid at %0d got %0b exp 0", nm, k, frame_sum_valid); end
        end
        tick;
        exp_cnt++;
        n_chk++; if (frame_sum_valid !== 1'b1) begin n_fail++; $display("FAIL %s valid got %0b exp 1", nm, frame_sum_valid); end
        n_chk++; if (frame_sum !== sum) begin n_fail++; $display("FAIL %s frame_sum got %0d exp %0d", nm, frame_sum, sum); end
        n_chk++; if (exposure !== exp_e) begin n_fail++; $display("FAIL %s exposure got %0d exp %0d", nm, exposure, exp_e); end
        n_chk++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL %s frame_cnt got %0h exp %0h", nm, frame_cnt, exp_cnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy got %0b exp 0", nm, busy); end
        tick;
        n_chk++; if (frame_sum_valid !== 1'b0) begin n_fail++; $display("FAIL %s valid width got %0b exp 0", nm, frame_sum_valid); end
    endtask

    task automatic do_frame(input logic [31:0] sum, input logic [15:0] exp_e, input string nm);
        fsync = 1'b1; tick; fsync = 1'b0;
        n_chk++; if (stats_roi !== roi_cfg) begin n_fail++; $display("FAIL %s stats_roi got %0h exp %0h", nm, stats_roi, roi_cfg); end
        n_chk++; if (busy !== 1'b1 || stats_rst !== 1'b1) begin n_fail++; $display("FAIL %s clear busy/rst got %0b%0b exp 11", nm, busy, stats_rst); end
        frame_body(sum, exp_e, 0, nm);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick; tick;
        check_idle_reset("reset", 16'h0400);
        rst_n = 1'b1; tick;
        rows(2);
        n_chk++; if (busy !== 1'b0 || stats_rst !== 1'b1) begin n_fail++; $display("FAIL idle_dv busy/rst got %0b%0b exp 01", busy, stats_rst); end
    endtask

    task automatic test_nominal;
        roi_cfg = 32'h11223344; ae_en = 1'b0;
        do_frame(32'd1000, 16'd1024, "nominal");
    endtask

    task automatic test_ae_up;
        ae_en = 1'b1; target = 32'd2000; hyst = 32'd100; step = 16'd64; exp_min = 16'd16; exp_max = 16'hFFFF;
        do_frame(32'd1000, 16'd1088, "ae_up");
        exp_max = 16'd1100;
        do_frame(32'd1000, 16'd1100, "ae_up_clamp");
        do_frame(32'd1000, 16'd1100, "ae_up_hold");
    endtask

    task automatic test_ae_down;
        step = 16'd1060;
        do_frame(32'd5000, 16'd40, "ae_down");
        step = 16'd64;
        do_frame(32'd5000, 16'd16, "ae_down_underflow");
        do_frame(32'd1950, 16'd16, "ae_band_hold");
        exp_min = 16'd500; exp_max = 16'd100;
        do_frame(32'd1000, 16'd16, "ae_bad_clamp");
        exp_min = 16'd16; exp_max = 16'd1100;
    endtask

    task automatic test_hyst_max;
        hyst = 32'hFFFFFFFF;
        do_frame(32'd0, 16'd16, "hyst_max_lo");
        do_frame(32'hFFFFFFFF, 16'd16, "hyst_max_hi");
        hyst = 32'd100; ae_en = 1'b0;
    endtask

    task automatic test_overrun;
        roi_cfg = 32'hAAAA0001;
        fsync = 1'b1; tick; fsync = 1'b0;
        rows(2);
        roi_cfg = 32'hBBBB0002;
        fsync = 1'b1; tick; fsync = 1'b0;
        n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b exp 1", overrun); end
        n_chk++; if (stats_rst !== 1'b1) begin n_fail++; $display("FAIL ovr_rst got %0b exp 1", stats_rst); end
        n_chk++; if (stats_roi !== 32'hBBBB0002) begin n_fail++; $display("FAIL ovr_roi got %0h exp bbbb0002", stats_roi); end
        n_chk++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL ovr_cnt got %0h exp %0h", frame_cnt, exp_cnt); end
        frame_body(32'd3000, 16'd16, 0, "ovr_frame");
        clr_err = 1'b1; tick; clr_err = 1'b0;
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got %0b exp 0", overrun); end
        fsync = 1'b1; tick; fsync = 1'b0; tick;
        fsync = 1'b1; clr_err = 1'b1; tick; fsync = 1'b0; clr_err = 1'b0;
        n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %0b exp 1", overrun); end
        frame_body(32'd3100, 16'd16, 0, "ovr_frame2");
        clr_err = 1'b1; tick; clr_err = 1'b0;
    endtask

    task automatic test_pend;
        roi_cfg = 32'hCCCC0003;
        fsync = 1'b1; tick; fsync = 1'b0;
        frame_body(32'd4000, 16'd16, 2, "pend_first");
        n_chk++; if (busy !== 1'b1 || stats_rst !== 1'b1) begin n_fail++; $display("FAIL pend_restart busy/rst got %0b%0b exp 11", busy, stats_rst); end
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL pend_overrun got %0b exp 0", overrun); end
        frame_body(32'd4100, 16'd16, 0, "pend_second");
    endtask

    task automatic test_wrap;
        force dut.frame_cnt_q = 16'hFFFF;
        tick;
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        n_chk++; if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %0h exp ffff", frame_cnt); end
        do_frame(32'd500, 16'd16, "wrap");
    endtask

    task automatic test_reset_mid;
        fsync = 1'b1; tick; fsync = 1'b0;
        rows(2);
        fsync = 1'b1; tick; fsync = 1'b0; tick;
        #2 rst_n = 1'b0;
        #1 check_idle_reset("reset_mid", 16'h0400);
        tick; rst_n = 1'b1; tick;
        exp_cnt = 16'd0;
        rows(2);
        n_chk++; if (busy !== 1'b0 || frame_sum_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle busy/valid got %0b%0b exp 00", busy, frame_sum_valid); end
        roi_cfg = 32'hDDDD0004;
        do_frame(32'd777, 16'h0400, "post_reset");
    endtask

    initial begin
        rst_n = 1'b0; fsync = 1'b0; dv = 1'b0; clr_err = 1'b0; ae_en = 1'b0;
        roi_cfg = '0; stats_sum = '0; target = '0; hyst = '0;
        step = '0; exp_min = '0; exp_max = 16'hFFFF;
        test_reset;
        test_nominal;
        test_ae_up;
        test_ae_down;
        test_hyst_max;
        test_overrun;
        test_pend;
        test_wrap;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
